// File: rtl/map_pkg.sv
// rtl/map_pkg.sv - shared map RAM geometry, tile codes, reader states and row field helper
package map_pkg;

    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;
    localparam int ROW_BITS = 160;

    typedef logic [3:0] tile_t;

    localparam tile_t TILE_EMPTY   = 4'h0;
    localparam tile_t TILE_DOT     = 4'h1;
    localparam tile_t TILE_PILL    = 4'h2;
    localparam tile_t TILE_PACMAN  = 4'h4;
    localparam tile_t TILE_GHOST   = 4'h5;
    localparam tile_t TILE_INVALID = 4'hF;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_CAPTURE,
        RD_RESP
    } rd_state_t;

    // Tile 0 sits in the top nibble of the row, so column x starts at bit 159-(4x+3).
    // The index is 8 bits wide with no wrap; callers guarantee x < MAP_COLS.
    function automatic tile_t tile_at(input logic [ROW_BITS-1:0] row, input logic [5:0] x);
        logic [7:0] idx;
        idx = 8'd156 - {x, 2'b00};
        return row[idx +: 4];
    endfunction

endpackage

// File: rtl/map_rr_arbiter.sv
// rtl/map_rr_arbiter.sv - round-robin arbiter: first requester at or after the pointer wins
module map_rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] next_ptr
);

    // Cyclic search from the pointer; the winner's successor becomes the next pointer.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                next_ptr = PW'((int'(idx) + 1) % N);
            end
        end
    end

endmodule

// File: rtl/map_ram_reader.sv
// rtl/map_ram_reader.sv - map RAM read responder; optional row cache enabled by MAP_READER_ROW_CACHE_EN
module map_ram_reader
    import map_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int RD_LATENCY  = 2,
    parameter int COLS        = MAP_COLS,
    parameter int ROWS        = MAP_ROWS
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic [NUM_CLIENTS-1:0]   req,
    input  logic [6*NUM_CLIENTS-1:0] qx,
    input  logic [5*NUM_CLIENTS-1:0] qy,
    output logic [4:0]               rdaddr,
    input  logic [159:0]             rddata,
    input  logic                     wr_snoop,
    input  logic [4:0]               wr_snoop_addr,
    output logic [NUM_CLIENTS-1:0]   resp_valid,
    output tile_t                    resp_tile,
    output logic                     busy
);

    localparam int         PW       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [2:0] LAT      = 3'(RD_LATENCY);
    localparam logic [5:0] COLS_LIM = 6'(COLS);
    localparam logic [5:0] ROWS_LIM = 6'(ROWS);

    rd_state_t              state_q, state_d;
    logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [5:0]             x_q, x_d;
    logic [4:0]             y_q, y_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [4:0]             rdaddr_d;
    tile_t                  tile_d;

    logic [NUM_CLIENTS-1:0] arb_gnt;
    logic [PW-1:0]          arb_next_ptr;
    logic [5:0]             sel_x;
    logic [4:0]             sel_y;
    logic                   out_of_range;
    logic [159:0]           capture_row;

    map_rr_arbiter #(
        .N(NUM_CLIENTS)
    ) u_arb (
        .req      (req),
        .ptr      (ptr_q),
        .gnt      (arb_gnt),
        .next_ptr (arb_next_ptr)
    );

    // Pick out the coordinates of whichever client the arbiter is granting.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (arb_gnt[i]) begin
                sel_x = qx[6*i +: 6];
                sel_y = qy[5*i +: 5];
            end
        end
    end

    assign out_of_range = (sel_x >= COLS_LIM) || ({1'b0, sel_y} >= ROWS_LIM);

`ifdef MAP_READER_ROW_CACHE_EN
    logic [159:0] cache_row;
    logic [4:0]   cache_tag;
    logic         cache_valid;
    logic         from_cache_q, from_cache_d;
    logic         cache_fill;
    logic [4:0]   inval_tag;
    logic         cache_hit;

    // A write to the cached row in the same cycle as the lookup forces a RAM read.
    assign cache_hit   = cache_valid && (sel_y == cache_tag) &&
                         !(wr_snoop && (wr_snoop_addr == cache_tag));
    assign capture_row = from_cache_q ? cache_row : rddata;
    assign cache_fill  = (state_q == RD_CAPTURE) && !from_cache_q;
    // While filling, the row being installed is the one a write must invalidate.
    assign inval_tag   = cache_fill ? y_q : cache_tag;

    // Row cache storage; any write to the tagged row drops the entry.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cache_row    <= '0;
            cache_tag    <= '0;
            cache_valid  <= 1'b0;
            from_cache_q <= 1'b0;
        end else begin
            from_cache_q <= from_cache_d;
            if (cache_fill) begin
                cache_row <= rddata;
                cache_tag <= y_q;
            end
            if (wr_snoop && (wr_snoop_addr == inval_tag)) begin
                cache_valid <= 1'b0;
            end else if (cache_fill) begin
                cache_valid <= 1'b1;
            end
        end
    end
`else
    assign capture_row = rddata;
`endif

    // Next-state and datapath updates for the IDLE/WAIT/CAPTURE/RESP sequence.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        rdaddr_d = rdaddr;
        tile_d   = resp_tile;
`ifdef MAP_READER_ROW_CACHE_EN
        from_cache_d = from_cache_q;
`endif
        case (state_q)
            RD_IDLE: begin
                if (|req) begin
                    gnt_d = arb_gnt;
                    ptr_d = arb_next_ptr;
                    x_d   = sel_x;
                    y_d   = sel_y;
`ifdef MAP_READER_ROW_CACHE_EN
                    from_cache_d = 1'b0;
`endif
                    if (out_of_range) begin
                        tile_d  = TILE_INVALID;
                        state_d = RD_RESP;
                    end
`ifdef MAP_READER_ROW_CACHE_EN
                    else if (cache_hit) begin
                        from_cache_d = 1'b1;
                        state_d      = RD_CAPTURE;
                    end
`endif
                    else begin
                        rdaddr_d = sel_y;
                        cnt_d    = LAT;
                        state_d  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (wr_snoop && (wr_snoop_addr == y_q)) begin
                    cnt_d = LAT;
                end else if (cnt_q <= 3'd1) begin
                    state_d = RD_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RD_CAPTURE: begin
                tile_d  = tile_at(capture_row, x_q);
                state_d = RD_RESP;
            end
            RD_RESP: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RD_IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            rdaddr    <= '0;
            resp_tile <= TILE_EMPTY;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            rdaddr    <= rdaddr_d;
            resp_tile <= tile_d;
        end
    end

    assign resp_valid = (state_q == RD_RESP) ? gnt_q : '0;
    assign busy       = (state_q != RD_IDLE);

endmodule

// File: tb/tb_map_ram_reader.sv
// tb/tb_map_ram_reader.sv - self-checking bench for map_ram_reader with a 2-cycle RAM model
module tb_map_ram_reader;
    import map_pkg::*;

    localparam int NC = 3;
`ifdef MAP_READER_ROW_CACHE_EN
    localparam int HIT_LAT = 2;
`else
    localparam int HIT_LAT = 4;
`endif

    logic            CLOCK_50 = 1'b0;
    logic            reset_n;
    logic [NC-1:0]   req;
    logic [6*NC-1:0] qx;
    logic [5*NC-1:0] qy;
    logic [4:0]      rdaddr;
    logic [159:0]    rddata;
    logic            wr_snoop;
    logic [4:0]      wr_snoop_addr;
    logic [NC-1:0]   resp_valid;
    tile_t           resp_tile;
    logic            busy;

    logic [159:0] wr_data;
    logic [159:0] mem [0:31];
    logic [159:0] img [0:31];
    logic [159:0] rd_pipe1, rd_pipe2;

    int checks = 0;
    int errors = 0;
    int cx[NC], cy[NC], ct[NC];
    int order[NC];
    int nstrobe[NC];
    int norder;

    typedef struct {
        int c;
        int x;
        int y;
        int tile;
        int lat;
        int addr;
    } vec_t;
    vec_t vt[8];

    always #5 CLOCK_50 = ~CLOCK_50;

    map_ram_reader #(
        .NUM_CLIENTS(NC),
        .RD_LATENCY (2),
        .COLS       (40),
        .ROWS       (30)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset_n       (reset_n),
        .req           (req),
        .qx            (qx),
        .qy            (qy),
        .rdaddr        (rdaddr),
        .rddata        (rddata),
        .wr_snoop      (wr_snoop),
        .wr_snoop_addr (wr_snoop_addr),
        .resp_valid    (resp_valid),
        .resp_tile     (resp_tile),
        .busy          (busy)
    );

    always @(posedge CLOCK_50) begin
        if (wr_snoop) mem[wr_snoop_addr] <= wr_data;
        rd_pipe1 <= mem[rdaddr];
        rd_pipe2 <= rd_pipe1;
    end
    assign rddata = rd_pipe2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic put_tile(input int row, input int x, input int t);
        img[row][156-4*x +: 4] = 4'(t);
    endtask

    task automatic ram_write(input int row);
        @(negedge CLOCK_50);
        wr_snoop      = 1'b1;
        wr_snoop_addr = 5'(row);
        wr_data       = img[row];
        @(negedge CLOCK_50);
        wr_snoop      = 1'b0;
    endtask

    task automatic set_client(input int c, input int x, input int y);
        qx[6*c +: 6] = 6'(x);
        qy[5*c +: 5] = 5'(y);
    endtask

    task automatic do_req(input int c, input int x, input int y,
                          input int snoop_row, input int snoop_x, input int snoop_t,
                          output int tile, output int lat, output int rv, output int ra);
        int  gcyc;
        bit  done;
        tile = -1; lat = -1; rv = -1; ra = -1; gcyc = -1; done = 1'b0;
        @(negedge CLOCK_50);
        set_client(c, x, y);
        req[c] = 1'b1;
        for (int cyc = 1; cyc <= 50 && !done; cyc++) begin
            @(negedge CLOCK_50);
            if (wr_snoop) wr_snoop = 1'b0;
            if (busy && gcyc < 0) begin
                gcyc = cyc;
                if (snoop_row >= 0) begin
                    put_tile(snoop_row, snoop_x, snoop_t);
                    wr_snoop      = 1'b1;
                    wr_snoop_addr = 5'(snoop_row);
                    wr_data       = img[snoop_row];
                end
            end
            if (resp_valid != '0) begin
                tile   = int'(resp_tile);
                lat    = cyc - gcyc + 1;
                rv     = int'(resp_valid);
                ra     = int'(rdaddr);
                req[c] = 1'b0;
                done   = 1'b1;
            end
        end
        if (!done) begin
            req[c] = 1'b0;
            checks++;
            errors++;
            $display("FAIL timeout: client %0d got no response", c);
        end
    endtask

    task automatic round(input logic [NC-1:0] mask);
        norder = 0;
        for (int i = 0; i < NC; i++) begin
            nstrobe[i] = 0;
            order[i]   = -1;
        end
        @(negedge CLOCK_50);
        for (int i = 0; i < NC; i++) begin
            if (mask[i]) begin
                set_client(i, cx[i], cy[i]);
                req[i] = 1'b1;
            end
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge CLOCK_50);
            if (resp_valid != '0) begin
                chk("strobe_onehot", $countones(resp_valid), 1);
                for (int i = 0; i < NC; i++) begin
                    if (resp_valid[i]) begin
                        chk($sformatf("round_tile_c%0d", i), int'(resp_tile), ct[i]);
                        if (norder < NC) order[norder] = i;
                        norder++;
                        nstrobe[i]++;
                        req[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        int  tile, lat, rv, ra;
        bit  seen;
        reset_n = 1'b0; req = '0; qx = '0; qy = '0;
        wr_snoop = 1'b0; wr_snoop_addr = '0; wr_data = '0;

        vt[0] = '{0,  7,  3, 1,  4, 3};
        vt[1] = '{1, 45,  2, 15, 1, 3};
        vt[2] = '{2,  0, 31, 15, 1, 3};
        vt[3] = '{1, 39,  0, 2,  4, 0};
        vt[4] = '{0,  0, 29, 5,  4, 29};
        vt[5] = '{2, 40,  0, 15, 1, 29};
        vt[6] = '{1, 20, 30, 15, 1, 29};
        vt[7] = '{2, 12,  3, 4,  4, 3};

        for (int r = 0; r < 32; r++) img[r] = '0;
        put_tile(3, 7, 1);  put_tile(3, 6, 2);  put_tile(3, 8, 5);  put_tile(3, 12, 4);
        put_tile(0, 39, 2); put_tile(0, 38, 1); put_tile(29, 0, 5); put_tile(29, 1, 2);
        put_tile(10, 4, 1); put_tile(11, 5, 2); put_tile(11, 6, 5);
        put_tile(4, 3, 2);  put_tile(4, 4, 1);
        for (int r = 0; r < 32; r++) ram_write(r);

        chk("reset_rdaddr", int'(rdaddr), 0);
        chk("reset_resp_valid", int'(resp_valid), 0);
        chk("reset_resp_tile", int'(resp_tile), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_req(vt[i].c, vt[i].x, vt[i].y, -1, 0, 0, tile, lat, rv, ra);
            chk($sformatf("vec%0d_tile", i), tile, vt[i].tile);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_resp_valid", i), rv, 1 << vt[i].c);
            chk($sformatf("vec%0d_rdaddr", i), ra, vt[i].addr);
        end

        cx[0] = 7; cy[0] = 3; ct[0] = 1;
        cx[1] = 6; cy[1] = 3; ct[1] = 2;
        cx[2] = 8; cy[2] = 3; ct[2] = 5;
        for (int r = 0; r < 2; r++) begin
            round(3'b111);
            for (int i = 0; i < NC; i++) begin
                chk($sformatf("round%0d_order%0d", r, i), order[i], i);
                chk($sformatf("round%0d_strobes_c%0d", r, i), nstrobe[i], 1);
            end
        end

        do_req(0, 5, 10, 10, 5, 4, tile, lat, rv, ra);
        chk("snoop_restart_tile", tile, 4);
        chk("snoop_restart_latency", lat, 5);
        chk("snoop_restart_rdaddr", ra, 10);

        do_req(0, 5, 11, 12, 5, 4, tile, lat, rv, ra);
        chk("snoop_other_row_tile", tile, 2);
        chk("snoop_other_row_latency", lat, 4);

        do_req(0, 3, 4, -1, 0, 0, tile, lat, rv, ra);
        chk("row4_first_tile", tile, 2);
        chk("row4_first_latency", lat, 4);
        do_req(0, 3, 4, -1, 0, 0, tile, lat, rv, ra);
        chk("row4_repeat_tile", tile, 2);
        chk("row4_repeat_latency", lat, HIT_LAT);
        put_tile(4, 3, 5);
        ram_write(4);
        do_req(0, 3, 4, -1, 0, 0, tile, lat, rv, ra);
        chk("row4_after_write_tile", tile, 5);
        chk("row4_after_write_latency", lat, 4);

        @(negedge CLOCK_50);
        set_client(1, 7, 3);
        req[1] = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge CLOCK_50);
            if (busy) seen = 1'b1;
        end
        chk("pre_reset_busy", int'(seen), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_rdaddr", int'(rdaddr), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_resp_valid", int'(resp_valid), 0);
        chk("async_reset_resp_tile", int'(resp_tile), 0);
        req = '0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        cx[1] = 7; cy[1] = 3; ct[1] = 1;
        cx[2] = 8; cy[2] = 3; ct[2] = 5;
        round(3'b110);
        chk("post_reset_first_grant", order[0], 1);
        chk("post_reset_second_grant", order[1], 2);
        chk("post_reset_strobes_c1", nstrobe[1], 1);
        chk("post_reset_strobes_c2", nstrobe[2], 1);
        chk("post_reset_strobes_c0", nstrobe[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
